// File: rtl/adder_share_arbiter.sv
// Shares one external WIDTH-bit ripple-carry adder between two requesters.
// Transactions are byte beats, LSB first; the carry is chained between beats of one transaction.
module adder_share_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [1:0]         req_sub,
   input  logic [1:0]         req_last,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_cin,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_cout,
   output logic               rsp_last
);

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       prio;
   logic       owner;
   logic       carry;
   logic       sub_l;

   logic       g;
   logic       s;
   logic       space;
   logic       accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // Grant, adder drive and next state; a locked owner keeps the adder until its last beat.
   always_comb begin
      g          = prio;
      s          = 1'b0;
      space      = 1'b0;
      accept     = 1'b0;
      req_ready  = 2'b00;
      sel_a      = '0;
      sel_b      = '0;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      next_state = state;

      if (state == LOCK) begin
         g = owner;
      end else if (req_valid[prio]) begin
         g = prio;
      end else if (req_valid[~prio]) begin
         g = ~prio;
      end

      sel_a = g ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
      sel_b = g ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
      s     = (state == LOCK) ? sub_l : req_sub[g];

      add_a   = sel_a;
      add_b   = s ? ~sel_b : sel_b;
      add_cin = (state == LOCK) ? carry : s;

      space        = !rsp_valid || rsp_ready;
      req_ready[g] = space && !rst;
      accept       = req_valid[g] && space && !rst;

      if (accept) begin
         next_state = req_last[g] ? IDLE : LOCK;
      end
   end

   // Registered result plus transaction bookkeeping; reset aborts any open transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prio      <= 1'b0;
         owner     <= 1'b0;
         carry     <= 1'b0;
         sub_l     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= g;
            rsp_last  <= req_last[g];
            carry     <= add_cout;
            if (state == IDLE) begin
               sub_l <= req_sub[g];
               owner <= g;
            end
            if (req_last[g]) begin
               prio <= ~g;
            end
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
